priority_match_encoder: RTL and testbench



---
 rtl/priority_match_encoder.sv | 125 ++++++++++++
 tb/tb_priority_match_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_match_encoder.sv
// Registered N-channel priority match encoder with valid/ready handshake on both sides.
// Reports winning channel (fixed highest-index or round-robin), match mask and match count.
module priority_match_encoder #(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 2,
  parameter  int MATCH_VALUE = 1,
  parameter  int NONE_CODE   = 0,
  parameter  int ROUND_ROBIN = 0,
  localparam int IDX_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_found,
  output logic [NUM_CH-1:0]        out_match_mask,
  output logic [IDX_W:0]           out_count
);

  localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(NONE_CODE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  // A match value wider than a channel can never be equal to any channel.
  localparam bit               MATCH_FITS = ((MATCH_VALUE >> DATA_W) == 0);

  logic              out_valid_reg;
  logic [IDX_W-1:0]  out_index_reg;
  logic              out_found_reg;
  logic [NUM_CH-1:0] out_mask_reg;
  logic [IDX_W:0]    out_count_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;

  logic [NUM_CH-1:0] match_mask;
  logic [IDX_W:0]    count_next;
  logic              found_next;
  logic [IDX_W-1:0]  fixed_idx;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_hit;
  logic [IDX_W-1:0]  cand_idx;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  rr_ptr_next;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_match
      assign match_mask[gi] = MATCH_FITS &&
                              (in_data[gi*DATA_W +: DATA_W] == DATA_W'(MATCH_VALUE));
    end
  endgenerate

  always_comb begin
    count_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      count_next = count_next + (IDX_W+1)'(match_mask[k]);
    end
  end

  assign found_next = |match_mask;

  always_comb begin
    fixed_idx = NONE_IDX;
    for (int k = 0; k < NUM_CH; k++) begin
      if (match_mask[k]) begin
        fixed_idx = IDX_W'(k);
      end
    end
  end

  // Round-robin walks downward from rr_ptr, wrapping below 0 to NUM_CH-1.
  always_comb begin
    rr_idx   = NONE_IDX;
    rr_hit   = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rr_ptr_reg) >= i) begin
        cand_idx = IDX_W'(int'(rr_ptr_reg) - i);
      end else begin
        cand_idx = IDX_W'(int'(rr_ptr_reg) + NUM_CH - i);
      end
      if (!rr_hit && match_mask[cand_idx]) begin
        rr_hit = 1'b1;
        rr_idx = cand_idx;
      end
    end
  end

  assign win_idx     = (ROUND_ROBIN != 0) ? rr_idx : fixed_idx;
  assign rr_ptr_next = (win_idx == '0) ? LAST_IDX : (win_idx - 1'b1);

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_index_reg <= NONE_IDX;
      out_found_reg <= 1'b0;
      out_mask_reg  <= '0;
      out_count_reg <= '0;
      rr_ptr_reg    <= LAST_IDX;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_index_reg <= win_idx;
      out_found_reg <= found_next;
      out_mask_reg  <= match_mask;
      out_count_reg <= count_next;
      if (found_next) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_index      = out_index_reg;
  assign out_found      = out_found_reg;
  assign out_match_mask = out_mask_reg;
  assign out_count      = out_count_reg;

endmodule

// File: tb/tb_priority_match_encoder.sv
// Self-checking bench: three encoder instances (fixed 4ch, round-robin 4ch, round-robin 5ch)
// share one handshake and are compared against a behavioural model of the output register.
module tb_priority_match_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  d4;
  logic [14:0] d5;

  logic       f_in_ready, f_valid, f_found;
  logic [1:0] f_idx;
  logic [3:0] f_mask;
  logic [2:0] f_cnt;
  logic       r_in_ready, r_valid, r_found;
  logic [1:0] r_idx;
  logic [3:0] r_mask;
  logic [2:0] r_cnt;
  logic       q_in_ready, q_valid, q_found;
  logic [2:0] q_idx;
  logic [4:0] q_mask;
  logic [3:0] q_cnt;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = fixed 4ch, 1 = round-robin 4ch, 2 = round-robin 5ch.
  int p_n  [3] = '{4, 4, 5};
  int p_dw [3] = '{2, 2, 3};
  int p_mv [3] = '{1, 1, 5};
  int p_rr [3] = '{0, 1, 1};
  bit m_valid [3];
  int m_idx   [3];
  bit m_found [3];
  int m_mask  [3];
  int m_cnt   [3];
  int m_ptr   [3];

  always #5 clk = ~clk;

  priority_match_encoder #(.NUM_CH(4), .DATA_W(2), .MATCH_VALUE(1), .NONE_CODE(0), .ROUND_ROBIN(0)) u_fix (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(f_in_ready), .in_data(d4),
    .out_valid(f_valid), .out_ready(out_ready), .out_index(f_idx), .out_found(f_found),
    .out_match_mask(f_mask), .out_count(f_cnt));

  priority_match_encoder #(.NUM_CH(4), .DATA_W(2), .MATCH_VALUE(1), .NONE_CODE(0), .ROUND_ROBIN(1)) u_rr (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(d4),
    .out_valid(r_valid), .out_ready(out_ready), .out_index(r_idx), .out_found(r_found),
    .out_match_mask(r_mask), .out_count(r_cnt));

  priority_match_encoder #(.NUM_CH(5), .DATA_W(3), .MATCH_VALUE(5), .NONE_CODE(0), .ROUND_ROBIN(1)) u_rr5 (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(q_in_ready), .in_data(d5),
    .out_valid(q_valid), .out_ready(out_ready), .out_index(q_idx), .out_found(q_found),
    .out_match_mask(q_mask), .out_count(q_cnt));

  // Winner for round-robin is the matching channel closest below-or-at the pointer (cyclically).
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] data;
      bit acc;
      int best_dist;
      data = (i == 2) ? 32'(d5) : 32'(d4);
      if (!reset_n) begin
        m_valid[i] = 0; m_idx[i] = 0; m_found[i] = 0; m_mask[i] = 0; m_cnt[i] = 0;
        m_ptr[i] = p_n[i] - 1;
      end else begin
        acc = in_valid && (!m_valid[i] || out_ready);
        if (acc) begin
          m_valid[i] = 1; m_mask[i] = 0; m_cnt[i] = 0; m_idx[i] = 0; best_dist = p_n[i];
          for (int k = 0; k < p_n[i]; k++) begin
            if (((data >> (k * p_dw[i])) & ((1 << p_dw[i]) - 1)) == p_mv[i]) begin
              m_mask[i] |= (1 << k);
              m_cnt[i]++;
              if (p_rr[i] == 0) m_idx[i] = (k > m_idx[i] || m_cnt[i] == 1) ? k : m_idx[i];
              else if (((m_ptr[i] - k + p_n[i]) % p_n[i]) < best_dist) begin
                best_dist = (m_ptr[i] - k + p_n[i]) % p_n[i];
                m_idx[i] = k;
              end
            end
          end
          m_found[i] = (m_cnt[i] > 0);
          if (m_found[i]) m_ptr[i] = (m_idx[i] + p_n[i] - 1) % p_n[i];
        end else if (out_ready) begin
          m_valid[i] = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit rn, input bit v, input bit r, input logic [7:0] a, input logic [14:0] b);
    reset_n = rn; in_valid = v; out_ready = r; d4 = a; d5 = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    $display("cycle t=%0t rst_n=%0b v=%0b rdy=%0b d4=%h d5=%h | fix v=%0b i=%0d m=%b | rr v=%0b i=%0d m=%b | rr5 v=%0b i=%0d m=%b c=%0d",
             $time, reset_n, in_valid, out_ready, d4, d5, f_valid, f_idx, f_mask,
             r_valid, r_idx, r_mask, q_valid, q_idx, q_mask, q_cnt);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'h00, 15'h0);
    tick();
    drive(1, 0, 0, 8'h00, 15'h0);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 8'h55, 15'h5B6D);
    tick();
    tick();
    checks++;
    if ({f_valid, f_idx, f_found, f_mask, f_cnt} !== 11'd0 || {r_valid, r_idx, r_found, r_mask, r_cnt} !== 11'd0 ||
        {q_valid, q_idx, q_found, q_mask, q_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: fix=%b rr=%b rr5=%b required all zero",
               {f_valid, f_idx, f_found, f_mask, f_cnt}, {r_valid, r_idx, r_found, r_mask, r_cnt},
               {q_valid, q_idx, q_found, q_mask, q_cnt});
    end
    checks++;
    if (f_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", f_in_ready);
    end
    drive(1, 0, 0, 8'h00, 15'h0);
  endtask

  task automatic test_fixed();
    do_reset();
    drive(1, 1, 1, 8'h1D, 15'h0);
    tick();
    checks++;
    if ({f_valid, f_idx, f_found, f_mask, f_cnt} !== {1'b1, 2'd2, 1'b1, 4'b0101, 3'd2}) begin
      errors++;
      $display("FAIL fixed_1D: got v=%b i=%0d f=%b m=%b c=%0d required v=1 i=2 f=1 m=0101 c=2",
               f_valid, f_idx, f_found, f_mask, f_cnt);
    end
    drive(1, 1, 1, 8'hFA, 15'h0);
    tick();
    checks++;
    if ({f_valid, f_idx, f_found, f_mask, f_cnt} !== {1'b1, 2'd0, 1'b0, 4'b0000, 3'd0}) begin
      errors++;
      $display("FAIL fixed_nomatch: got v=%b i=%0d f=%b m=%b c=%0d required v=1 i=0 f=0 m=0000 c=0",
               f_valid, f_idx, f_found, f_mask, f_cnt);
    end
    drive(1, 0, 1, 8'h00, 15'h0);
    tick();
    checks++;
    if (f_valid !== 1'b0) begin
      errors++;
      $display("FAIL fixed_drain: out_valid got %b required 0", f_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [7] = '{3, 2, 1, 0, 3, 2, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 1, (i < 5) ? 8'h55 : 8'h11, 15'h0);
      tick();
      checks++;
      if (r_valid !== 1'b1 || int'(r_idx) != exp_seq[i] || r_found !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b i=%0d f=%b required v=1 i=%0d f=1", i, r_valid, r_idx, r_found, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 1, 1, 8'h1D, 15'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 8'h55, 15'h0);
      checks++;
      if (f_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b required 0", i, f_in_ready);
      end
      tick();
      checks++;
      if (f_valid !== 1'b1 || f_idx !== 2'd2 || f_mask !== 4'b0101 || r_idx !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b fi=%0d m=%b ri=%0d required v=1 fi=2 m=0101 ri=2",
                 i, f_valid, f_idx, f_mask, r_idx);
      end
    end
    drive(1, 1, 1, 8'h55, 15'h0);
    checks++;
    if (f_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b required 1", f_in_ready);
    end
    tick();
    checks++;
    if (f_valid !== 1'b1 || f_idx !== 2'd3 || f_mask !== 4'b1111) begin
      errors++;
      $display("FAIL bp_release: got v=%b i=%0d m=%b required v=1 i=3 m=1111", f_valid, f_idx, f_mask);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 8'(32'h0 + $urandom), 15'h0);
      tick();
      checks++;
      if (f_valid !== 1'b1 || int'(r_idx) != m_idx[1] || f_mask !== 4'(m_mask[0])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got v=%b ri=%0d fm=%b required v=1 ri=%0d fm=%b",
                 i, f_valid, r_idx, f_mask, m_idx[1], 4'(m_mask[0]));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 1, 8'h55, 15'h0);
    tick();
    tick();
    drive(0, 1, 1, 8'h55, 15'h0);
    tick();
    checks++;
    if ({r_valid, r_idx, r_found, r_mask, r_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %b required all zero", {r_valid, r_idx, r_found, r_mask, r_cnt});
    end
    drive(1, 1, 1, 8'h55, 15'h0);
    tick();
    checks++;
    if (r_valid !== 1'b1 || r_idx !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_ptr: got v=%b i=%0d required v=1 i=3", r_valid, r_idx);
    end
  endtask

  task automatic test_rr5();
    int exp_seq [6] = '{4, 3, 2, 1, 0, 4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, 8'h00, {5{3'd5}});
      tick();
      checks++;
      if (q_valid !== 1'b1 || int'(q_idx) != exp_seq[i] || q_cnt !== 4'd5 || q_mask !== 5'b11111) begin
        errors++;
        $display("FAIL rr5_seq[%0d]: got v=%b i=%0d c=%0d m=%b required v=1 i=%0d c=5 m=11111",
                 i, q_valid, q_idx, q_cnt, q_mask, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [14:0] b;
      for (int k = 0; k < 5; k++) b[k*3 +: 3] = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'($urandom);
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            8'($urandom), b);
      checks++;
      if (f_in_ready !== (!m_valid[0] || out_ready) || q_in_ready !== (!m_valid[2] || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b/%b required %b", n, f_in_ready, q_in_ready, (!m_valid[0] || out_ready));
      end
      tick();
      checks++;
      if ({f_valid, f_idx, f_found, f_mask, f_cnt} !==
          {m_valid[0], 2'(m_idx[0]), m_found[0], 4'(m_mask[0]), 3'(m_cnt[0])}) begin
        errors++;
        $display("FAIL rand_fix[%0d]: got v=%b i=%0d m=%b c=%0d required v=%b i=%0d m=%b c=%0d", n,
                 f_valid, f_idx, f_mask, f_cnt, m_valid[0], m_idx[0], 4'(m_mask[0]), m_cnt[0]);
      end
      checks++;
      if ({r_valid, r_idx, r_found, r_mask, r_cnt} !==
          {m_valid[1], 2'(m_idx[1]), m_found[1], 4'(m_mask[1]), 3'(m_cnt[1])}) begin
        errors++;
        $display("FAIL rand_rr[%0d]: got v=%b i=%0d m=%b c=%0d required v=%b i=%0d m=%b c=%0d", n,
                 r_valid, r_idx, r_mask, r_cnt, m_valid[1], m_idx[1], 4'(m_mask[1]), m_cnt[1]);
      end
      checks++;
      if ({q_valid, q_idx, q_found, q_mask, q_cnt} !==
          {m_valid[2], 3'(m_idx[2]), m_found[2], 5'(m_mask[2]), 4'(m_cnt[2])}) begin
        errors++;
        $display("FAIL rand_rr5[%0d]: got v=%b i=%0d m=%b c=%0d required v=%b i=%0d m=%b c=%0d", n,
                 q_valid, q_idx, q_mask, q_cnt, m_valid[2], m_idx[2], 5'(m_mask[2]), m_cnt[2]);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 8'h00, 15'h0);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_rr5();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
